// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl_if
//  Description : Data-memory bus between the MEM-stage controller (master)
//                and the data memory (slave). Request-side signals are held
//                stable by the master until the single-cycle ack arrives.
//  Signals     : mem_req   master->slave  bus request
//                mem_we    master->slave  1 = write, 0 = read
//                mem_addr  master->slave  word-aligned byte address
//                mem_wdata master->slave  store data
//                mem_rdata slave->master  read data, valid with mem_ack
//                mem_ack   slave->master  single-cycle completion strobe
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl
//  Description : MEM-stage controller of the 5-stage MIPS pipeline. Runs a
//                req/ack data-memory transaction for aligned loads/stores,
//                stalls upstream stages while it is in flight, owns the
//                MEM/WB register, and flags misaligned accesses and bus
//                timeouts (both sticky until reset).
//  Ports       : clk, rst          clock, async active-high reset
//                i_alu_result      EX/MEM ALU result / memory byte address
//                i_store_data      EX/MEM store data (rt)
//                i_dest_reg        EX/MEM destination register
//                i_mem2reg         load: write-back value from memory
//                i_memwr           store
//                i_regwr           register write enable
//                o_stall           combinational hold of EX/MEM and earlier
//                bus               data-memory bus (master modport)
//                o_wb_value/dest/regwr  MEM/WB register outputs
//                o_err_align       sticky misaligned-access flag
//                o_err_bus         sticky bus-timeout flag
//  Parameters  : TIMEOUT           max BUSY cycles without ack (>= 2)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  wire               clk,
  input  wire               rst,
  input  wire        [31:0] i_alu_result,
  input  wire        [31:0] i_store_data,
  input  wire        [4:0]  i_dest_reg,
  input  wire               i_mem2reg,
  input  wire               i_memwr,
  input  wire               i_regwr,
  output logic              o_stall,
  mem_stage_ctrl_if.master  bus,
  output logic       [31:0] o_wb_value,
  output logic       [4:0]  o_wb_dest,
  output logic              o_wb_regwr,
  output logic              o_err_align,
  output logic              o_err_bus
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_rdata_q;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [31:0]     r_mem_addr;
  logic [31:0]     r_mem_wdata;
  logic [31:0]     r_wb_value;
  logic [4:0]      r_wb_dest;
  logic            r_wb_regwr;
  logic            r_err_align;
  logic            r_err_bus;

  logic            w_memop;
  logic            w_aligned;

  assign w_memop   = i_mem2reg | i_memwr;
  assign w_aligned = (i_alu_result[1:0] == 2'b00);

  // rst is folded in so the stall drops immediately on an asynchronous reset,
  // even while the held EX/MEM fields still describe an aligned memory op.
  assign o_stall = ~rst & (((r_state == S_IDLE) & w_memop & w_aligned) |
                           (r_state == S_BUSY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rdata_q   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wb_value  <= '0;
      r_wb_dest   <= '0;
      r_wb_regwr  <= 1'b0;
      r_err_align <= 1'b0;
      r_err_bus   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_memop) begin
            r_wb_value <= i_alu_result;
            r_wb_dest  <= i_dest_reg;
            r_wb_regwr <= i_regwr;
          end else if (!w_aligned) begin
            // Misaligned access is squashed: no bus cycle, no register write.
            r_wb_value  <= i_alu_result;
            r_wb_dest   <= i_dest_reg;
            r_wb_regwr  <= 1'b0;
            r_err_align <= 1'b1;
          end else begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_memwr;
            r_mem_addr  <= {i_alu_result[31:2], 2'b00};
            r_mem_wdata <= i_store_data;
            r_cnt       <= '0;
            r_wb_regwr  <= 1'b0;
            r_state     <= S_BUSY;
          end
        end

        S_BUSY: begin
          r_wb_regwr <= 1'b0;
          // Ack has priority over the timeout on the same cycle.
          if (bus.mem_ack) begin
            r_rdata_q <= bus.mem_rdata;
            r_mem_req <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_cnt == c_CNT_LAST) begin
            r_rdata_q <= '0;
            r_mem_req <= 1'b0;
            r_err_bus <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DONE: begin
          // EX/MEM is released on this same edge, so its fields still
          // describe the completed instruction here.
          r_wb_value <= i_mem2reg ? r_rdata_q : i_alu_result;
          r_wb_dest  <= i_dest_reg;
          r_wb_regwr <= i_regwr;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

  assign o_wb_value  = r_wb_value;
  assign o_wb_dest   = r_wb_dest;
  assign o_wb_regwr  = r_wb_regwr;
  assign o_err_align = r_err_align;
  assign o_err_bus   = r_err_bus;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_ctrl
//  Description : Self-checking bench for mem_stage_ctrl. Each instruction is
//                expanded into its cycle timeline (stall, bus request, bubble
//                and write-back) from the transaction rules; a compare process
//                checks every cycle, and literal pins anchor directed cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_alu_result, i_store_data;
  logic [4:0]  i_dest_reg;
  logic        i_mem2reg, i_memwr, i_regwr;
  logic        o_stall;
  logic [31:0] o_wb_value;
  logic [4:0]  o_wb_dest;
  logic        o_wb_regwr, o_err_align, o_err_bus;

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_alu_result (i_alu_result),
    .i_store_data (i_store_data),
    .i_dest_reg   (i_dest_reg),
    .i_mem2reg    (i_mem2reg),
    .i_memwr      (i_memwr),
    .i_regwr      (i_regwr),
    .o_stall      (o_stall),
    .bus          (bus.master),
    .o_wb_value   (o_wb_value),
    .o_wb_dest    (o_wb_dest),
    .o_wb_regwr   (o_wb_regwr),
    .o_err_align  (o_err_align),
    .o_err_bus    (o_err_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected values for the current cycle, and for the cycle after the next edge.
  logic        exp_valid = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_wb_regwr, exp_wb_chk, exp_err_align, exp_err_bus;
  logic [31:0] exp_addr, exp_wdata, exp_wb_value;
  logic [4:0]  exp_wb_dest;
  logic        nx_req, nx_we, nx_wb_regwr, nx_wb_chk, nx_err_align, nx_err_bus;
  logic [31:0] nx_addr, nx_wdata, nx_wb_value;
  logic [4:0]  nx_wb_dest;

  // Staged EX/MEM fields, applied at the start of each cycle.
  logic [31:0] s_alu, s_sd;
  logic [4:0]  s_dst;
  logic        s_m2r, s_mw, s_rw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid && !rst) begin
      chk("stall", o_stall, exp_stall);
      chk("mem_req", bus.mem_req, exp_req);
      chk("mem_we", bus.mem_we, exp_we);
      chk("mem_addr", bus.mem_addr, exp_addr);
      chk("mem_wdata", bus.mem_wdata, exp_wdata);
      chk("wb_regwr", o_wb_regwr, exp_wb_regwr);
      if (exp_wb_chk) begin
        chk("wb_value", o_wb_value, exp_wb_value);
        chk("wb_dest", o_wb_dest, exp_wb_dest);
      end
      chk("err_align", o_err_align, exp_err_align);
      chk("err_bus", o_err_bus, exp_err_bus);
    end
  end

  function automatic logic spur();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic model_reset();
    nx_req = 0; nx_we = 0; nx_addr = 0; nx_wdata = 0;
    nx_wb_value = 0; nx_wb_dest = 0; nx_wb_regwr = 0; nx_wb_chk = 1;
    nx_err_align = 0; nx_err_bus = 0;
  endtask

  task automatic step(input logic st, input logic ak, input logic [31:0] rd);
    @(posedge clk); #1;
    i_alu_result = s_alu; i_store_data = s_sd; i_dest_reg = s_dst;
    i_mem2reg = s_m2r; i_memwr = s_mw; i_regwr = s_rw;
    bus.mem_ack = ak; bus.mem_rdata = rd;
    exp_stall = st;
    exp_req = nx_req; exp_we = nx_we; exp_addr = nx_addr; exp_wdata = nx_wdata;
    exp_wb_value = nx_wb_value; exp_wb_dest = nx_wb_dest;
    exp_wb_regwr = nx_wb_regwr; exp_wb_chk = nx_wb_chk;
    exp_err_align = nx_err_align; exp_err_bus = nx_err_bus;
    exp_valid = 1'b1;
  endtask

  // ack_at: BUSY cycle (1-based) carrying the ack; outside 1..TIMEOUT = never.
  // rst_busy: BUSY cycle in which an asynchronous reset is pulsed (0 = none).
  task automatic run_instr(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dst,
                           input logic m2r, input logic mw, input logic rw,
                           input int ack_at, input logic [31:0] rd, input int rst_busy);
    logic memop, aligned, acked;
    int n;
    memop = m2r | mw;
    aligned = (alu[1:0] == 2'b00);
    acked = (ack_at >= 1) && (ack_at <= TIMEOUT);
    s_alu = alu; s_sd = sd; s_dst = dst; s_m2r = m2r; s_mw = mw; s_rw = rw;
    if (!(memop && aligned)) begin
      step(1'b0, spur(), $urandom);
      nx_wb_value = alu; nx_wb_dest = dst; nx_wb_regwr = memop ? 1'b0 : rw; nx_wb_chk = 1;
      if (memop) nx_err_align = 1;
    end else begin
      n = acked ? ack_at : TIMEOUT;
      step(1'b1, spur(), $urandom);
      nx_wb_regwr = 0; nx_wb_chk = 0;
      nx_req = 1; nx_we = mw; nx_addr = alu; nx_wdata = sd;
      for (int i = 1; i <= n; i++) begin
        step(1'b1, (i == ack_at), (i == ack_at) ? rd : $urandom);
        nx_wb_regwr = 0; nx_wb_chk = 0;
        if (i == rst_busy) begin
          #2;
          exp_valid = 1'b0;
          rst = 1'b1;
          #1;
          chk("rst_stall", o_stall, 0);
          chk("rst_mem_req", bus.mem_req, 0);
          chk("rst_wb_value", o_wb_value, 0);
          chk("rst_wb_dest", o_wb_dest, 0);
          chk("rst_wb_regwr", o_wb_regwr, 0);
          chk("rst_err_bus", o_err_bus, 0);
          chk("rst_err_align", o_err_align, 0);
          @(posedge clk); #2;
          s_alu = 0; s_sd = 0; s_dst = 0; s_m2r = 0; s_mw = 0; s_rw = 0;
          i_alu_result = 0; i_store_data = 0; i_dest_reg = 0;
          i_mem2reg = 0; i_memwr = 0; i_regwr = 0;
          bus.mem_ack = 0;
          rst = 1'b0;
          model_reset();
          return;
        end
      end
      nx_req = 0;
      if (!acked) nx_err_bus = 1;
      step(1'b0, spur(), $urandom);
      nx_wb_value = m2r ? (acked ? rd : 32'h0) : alu;
      nx_wb_dest = dst; nx_wb_regwr = rw; nx_wb_chk = 1;
    end
  endtask

  // Runs a NOP and pins the write-back of the preceding instruction.
  task automatic pin_next(input logic [31:0] v, input logic [4:0] d, input logic w);
    run_instr(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 0);
    @(negedge clk); #1;
    chk("pin_wb_value", o_wb_value, v);
    chk("pin_wb_dest", o_wb_dest, d);
    chk("pin_wb_regwr", o_wb_regwr, w);
  endtask

  initial begin
    logic [31:0] alu;
    int kind;
    // Reset state, with an aligned load presented so stall gating is exercised.
    i_alu_result = 32'h40; i_store_data = 0; i_dest_reg = 5'd1;
    i_mem2reg = 1; i_memwr = 0; i_regwr = 1;
    bus.mem_ack = 1; bus.mem_rdata = 32'h1111_1111;
    #3;
    chk("reset_stall", o_stall, 0);
    chk("reset_mem_req", bus.mem_req, 0);
    chk("reset_wb_regwr", o_wb_regwr, 0);
    chk("reset_err_align", o_err_align, 0);
    #5;
    i_mem2reg = 0; i_regwr = 0; i_alu_result = 0; i_dest_reg = 0; bus.mem_ack = 0;
    s_alu = 0; s_sd = 0; s_dst = 0; s_m2r = 0; s_mw = 0; s_rw = 0;
    rst = 1'b0;
    model_reset();

    // ADD result passes straight through.
    run_instr(32'h0000_1234, 32'h0, 5'd5, 0, 0, 1, 0, 32'h0, 0);
    pin_next(32'h0000_1234, 5'd5, 1'b1);
    // Load, ack in first BUSY cycle.
    run_instr(32'h100, 32'h0, 5'd8, 1, 0, 1, 1, 32'hDEAD_BEEF, 0);
    pin_next(32'hDEAD_BEEF, 5'd8, 1'b1);
    chk("pin_addr_load", bus.mem_addr, 32'h100);
    // Store, ack after 3 wait cycles (coincides with the timeout cycle: ack wins).
    run_instr(32'h204, 32'hCAFE_F00D, 5'd0, 0, 1, 0, 4, 32'h0, 0);
    pin_next(32'h204, 5'd0, 1'b0);
    chk("pin_we_store", bus.mem_we, 1);
    chk("pin_wdata_store", bus.mem_wdata, 32'hCAFE_F00D);
    chk("pin_err_bus_ack_wins", o_err_bus, 0);
    // Load with ack in last allowed BUSY cycle.
    run_instr(32'h3F0, 32'h0, 5'd2, 1, 0, 1, TIMEOUT, 32'h55AA_1234, 0);
    pin_next(32'h55AA_1234, 5'd2, 1'b1);
    chk("pin_err_bus_late_ack", o_err_bus, 0);
    // Misaligned load.
    run_instr(32'h102, 32'h0, 5'd7, 1, 0, 1, 1, 32'h0, 0);
    pin_next(32'h102, 5'd7, 1'b0);
    chk("pin_err_align", o_err_align, 1);
    // Load with no ack: timeout.
    run_instr(32'h400, 32'h0, 5'd9, 1, 0, 1, 0, 32'h0, 0);
    pin_next(32'h0, 5'd9, 1'b1);
    chk("pin_err_bus", o_err_bus, 1);
    // Reset in the 2nd BUSY cycle; then an ack pulse that must be ignored.
    run_instr(32'h300, 32'h0, 5'd4, 1, 0, 1, 0, 32'h0, 2);
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    nx_wb_value = 0; nx_wb_dest = 0; nx_wb_regwr = 0; nx_wb_chk = 1;
    run_instr(32'h0000_0ABC, 32'h0, 5'd3, 0, 0, 1, 0, 32'h0, 0);
    pin_next(32'h0000_0ABC, 5'd3, 1'b1);

    // Randomized instruction stream.
    for (int k = 0; k < 200; k++) begin
      kind = $urandom_range(0, 9);
      alu = $urandom;
      if (kind >= 4) begin
        if ($urandom_range(0, 4) == 0) alu[1:0] = 2'($urandom_range(1, 3));
        else alu[1:0] = 2'b00;
      end
      if (kind < 4)
        run_instr(alu, $urandom, 5'($urandom), 0, 0, 1'($urandom), 0, 32'h0, 0);
      else if (kind < 7)
        run_instr(alu, $urandom, 5'($urandom), 1, 0, 1,
                  $urandom_range(0, TIMEOUT), $urandom, 0);
      else
        run_instr(alu, $urandom, 5'($urandom), 0, 1, 0,
                  $urandom_range(0, TIMEOUT), $urandom, 0);
    end
    run_instr(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 32'h0, 0);
    step(1'b0, 1'b0, 32'h0);
    @(negedge clk); #1;
    exp_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller of the 5-stage MIPS pipeline. It consumes the fields held in the EX/MEM pipeline register and runs a req/ack transaction on the data-memory bus for loads and stores, stalling the upstream pipeline while the access is in flight. It owns the MEM/WB register and presents the write-back value, destination and write enable to the WB stage. It also flags misaligned accesses and bus timeouts.

## Interface
- TIMEOUT, 16: max consecutive BUSY cycles without mem_ack before abort (≥2)
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_result  in  32  EX/MEM ALU result; memory byte address for loads/stores
- store_data  in  32  EX/MEM rt value, store data
- dest_reg  in  5  EX/MEM destination register
- mem2reg  in  1  load: write-back value comes from memory
- memwr  in  1  store
- regwr  in  1  register write enable of the instruction
- stall  out  1  combinational; 1 holds EX/MEM and all earlier stages
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 = write, registered
- mem_addr  out  32  word-aligned address, registered
- mem_wdata  out  32  store data, registered
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  single-cycle completion strobe
- wb_value  out  32  MEM/WB write-back value
- wb_dest  out  5  MEM/WB destination
- wb_regwr  out  1  MEM/WB write enable
- err_align  out  1  sticky: misaligned load/store seen
- err_bus  out  1  sticky: bus timeout seen

## Operation
- memop = mem2reg | memwr; aligned = (alu_result[1:0] == 0).
- States: IDLE, BUSY, DONE. Reset: IDLE, all outputs and internal regs 0.
- stall = (IDLE & memop & aligned) | BUSY. In DONE, stall = 0.
- IDLE, no memop: MEM/WB loads {alu_result, dest_reg, regwr}. Stay in IDLE.
- IDLE, memop, misaligned: no bus access. MEM/WB loads {alu_result, dest_reg, 0}, err_align ← 1. Stay in IDLE, no stall.
- IDLE, memop, aligned: mem_req ← 1, mem_we ← memwr, mem_addr ← alu_result, mem_wdata ← store_data, cnt ← 0. MEM/WB loads a bubble (wb_regwr 0). Next state: BUSY.
- BUSY: mem_req, mem_we, mem_addr and mem_wdata are held stable. MEM/WB loads a bubble each cycle.
  - mem_ack = 1: rdata_q ← mem_rdata, mem_req ← 0, go to DONE.
  - no ack and cnt == TIMEOUT-1: rdata_q ← 0, mem_req ← 0, err_bus ← 1, go to DONE.
  - otherwise: cnt ← cnt+1.
- DONE: MEM/WB loads {mem2reg ? rdata_q : alu_result, dest_reg, regwr}. EX/MEM advances on the same edge. Next state: IDLE.
- mem_ack outside BUSY is ignored.
- err_align and err_bus clear only on rst.
- mem_we, mem_addr and mem_wdata keep their last value while mem_req = 0.

## Timing
- Non-memory op: 1 cycle in MEM, no stall. Result is on the wb_* outputs after the next edge.
- Aligned memory op, ack in the first BUSY cycle: 3 cycles (IDLE→BUSY→DONE), stall high for 2 cycles. Each extra wait cycle adds 1 cycle.
- mem_req rises on the edge leaving IDLE and falls on the edge where the ack is sampled. mem_req is never high for more than TIMEOUT cycles.
- Ack arriving in the same cycle as the timeout condition: the ack wins, data is captured and err_bus is not set.
- Back-to-back memory ops: DONE→IDLE, then the next op is detected in IDLE. There is 1 non-stalled cycle between transactions.
- rst asserted mid-transaction: mem_req, stall and all outputs go to 0 immediately (asynchronous), state goes to IDLE. An ack after reset is ignored.

## Test plan
- ADD result 0x0000_1234, dest 5, regwr 1, no memop → next edge wb_value=0x1234, wb_dest=5, wb_regwr=1; stall never 1; mem_req never 1.
- Load at 0x100, dest 8, ack in the first BUSY cycle with rdata 0xDEADBEEF → mem_req 1 for 1 cycle with addr 0x100 and we 0; stall 1 for 2 cycles; wb_value=0xDEADBEEF, wb_dest=8, wb_regwr=1; wb_regwr 0 during the two bubble cycles.
- Store at 0x204, data 0xCAFEF00D, ack after 3 wait cycles → mem_we=1, mem_wdata=0xCAFEF00D held for 4 cycles; stall 1 for 5 cycles; wb_regwr=0.
- Load at 0x102 (misaligned) → mem_req stays 0, stall 0, err_align=1 after the edge, wb_regwr=0.
- TIMEOUT=4, load with no ack → mem_req high exactly 4 cycles, then err_bus=1, wb_value=0, wb_regwr=1. Repeat with the ack in BUSY cycle 4 → data captured, err_bus stays 0.
- rst pulse in the 2nd BUSY cycle → mem_req, stall and the wb_* outputs go to 0 without a clock edge. A later ack pulse changes nothing, and the next ADD passes through normally.
